// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared FSM state type, reference-gate op codes and settle counter width.
package gate_sweep_pkg;
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_SAMPLE, S_DONE} state_t;
    localparam int OP_OR    = 0;
    localparam int OP_AND   = 1;
    localparam int OP_XOR   = 2;
    localparam int OP_NOR   = 3;
    localparam int OP_NAND  = 4;
    localparam int OP_XNOR  = 5;
    localparam int SETTLE_W = 4;
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden output for the gate under test, selected by OP.
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int OP   = OP_OR
) (
    input  logic [N_IN-1:0] i_vec,
    output logic            o_expected
);
    logic w_red;
    always_comb begin
        w_red      = (OP == OP_OR || OP == OP_NOR) ? |i_vec :
                     (OP == OP_AND || OP == OP_NAND) ? &i_vec : ^i_vec;
        // unsupported op codes read as a constant 0 reference
        o_expected = (OP < OP_OR || OP > OP_XNOR) ? 1'b0 :
                     (OP >= OP_NOR) ? ~w_red : w_red;
    end
endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive stimulus/compare sequencer for a small gate; GATE_SWEEP_CAPTURE_EN adds first-failure capture.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int OP     = OP_OR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    output logic [N_IN-1:0] o_gate_in,
    input  logic            i_gate_z,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_count
`ifdef GATE_SWEEP_CAPTURE_EN
    ,
    output logic [N_IN-1:0] o_first_fail_vec,
    output logic            o_first_fail_z
`endif
);
    localparam logic [N_IN-1:0]     VEC_MAX  = '1;
    localparam logic [N_IN:0]       ERR_MAX  = {1'b1, {N_IN{1'b0}}};
    localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE);

    state_t              r_state;
    logic [N_IN-1:0]     r_vec;
    logic [SETTLE_W-1:0] r_cnt;
    logic                w_expected;
    logic                w_miss;
    logic [N_IN:0]       w_err_next;
`ifdef GATE_SWEEP_CAPTURE_EN
    logic                r_captured;
`endif

    gate_ref_model #(.N_IN(N_IN), .OP(OP)) u_ref (
        .i_vec      (r_vec),
        .o_expected (w_expected)
    );

    assign w_miss     = i_gate_z != w_expected;
    assign w_err_next = (w_miss && o_err_count != ERR_MAX) ? o_err_count + 1'b1 : o_err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            o_gate_in   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_err_count <= '0;
`ifdef GATE_SWEEP_CAPTURE_EN
            r_captured       <= 1'b0;
            o_first_fail_vec <= '0;
            o_first_fail_z   <= 1'b0;
`endif
        end else if (i_abort && r_state inside {S_DRIVE, S_WAIT, S_SAMPLE}) begin
            // abort beats the compare: the sample in flight is dropped
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
            o_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state     <= S_DRIVE;
                    r_vec       <= '0;
                    o_err_count <= '0;
                    o_pass      <= 1'b0;
                    o_busy      <= 1'b1;
`ifdef GATE_SWEEP_CAPTURE_EN
                    r_captured       <= 1'b0;
                    o_first_fail_vec <= '0;
                    o_first_fail_z   <= 1'b0;
`endif
                end
                S_DRIVE: begin
                    o_gate_in <= r_vec;
                    r_cnt     <= SETTLE_L;
                    r_state   <= (SETTLE == 0) ? S_SAMPLE : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SETTLE_W'(1))
                        r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    o_err_count <= w_err_next;
`ifdef GATE_SWEEP_CAPTURE_EN
                    if (w_miss && !r_captured) begin
                        r_captured       <= 1'b1;
                        o_first_fail_vec <= r_vec;
                        o_first_fail_z   <= i_gate_z;
                    end
`endif
                    if (r_vec == VEC_MAX) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                        o_pass  <= w_err_next == '0;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: two sweepers (OR/SETTLE=2 and XOR/SETTLE=0) driven by modelled gates, checked against an arithmetic reference.
module tb_gate_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [1:0] gate_in0, gate_in1;
    logic       z0, z1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [2:0] err0, err1;
    int         mode0 = 0;
    logic [3:0] lut0 = 4'b0000, lut1 = 4'b0110;
    int         n_checks = 0, n_fail = 0;
`ifdef GATE_SWEEP_CAPTURE_EN
    logic [1:0] ffv0, ffv1;
    logic       ffz0, ffz1;
`endif

    always #5 clk = ~clk;

    assign z0 = (mode0 == 0) ? |gate_in0 : (mode0 == 1) ? 1'b0 : (mode0 == 2) ? 1'b1 : lut0[gate_in0];
    assign z1 = lut1[gate_in1];

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(2), .OP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start0), .i_abort(abort0),
        .o_gate_in(gate_in0), .i_gate_z(z0), .o_busy(busy0), .o_done(done0),
        .o_pass(pass0), .o_err_count(err0)
`ifdef GATE_SWEEP_CAPTURE_EN
        , .o_first_fail_vec(ffv0), .o_first_fail_z(ffz0)
`endif
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(0), .OP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort1),
        .o_gate_in(gate_in1), .i_gate_z(z1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_err_count(err1)
`ifdef GATE_SWEEP_CAPTURE_EN
        , .o_first_fail_vec(ffv1), .o_first_fail_z(ffz1)
`endif
    );

    function automatic logic ref_fn(input int op, input int v);
        int c;
        c = $countones(v);
        case (op)
            0: return c > 0;
            1: return c == 2;
            2: return c % 2 == 1;
            3: return !(c > 0);
            4: return !(c == 2);
            5: return c % 2 == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic kick(input int sel);
        @(posedge clk); #1;
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Watches one sweep from the acceptance edge; optionally pulses start/abort at cycle index.
    task automatic observe(input int sel, input int start_at, input int abort_at,
                           output int busy_cyc, output int done_cnt, output int done_at, output logic pass_done);
        logic b, d, p;
        busy_cyc = 0; done_cnt = 0; done_at = -1; pass_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            b = sel ? busy1 : busy0;
            d = sel ? done1 : done0;
            p = sel ? pass1 : pass0;
            if (d) begin
                done_cnt++;
                done_at = i;
                pass_done = p;
            end
            if (!b) break;
            busy_cyc++;
            if (sel == 0) begin
                start0 = (i == start_at);
                abort0 = (i == abort_at);
            end else begin
                start1 = (i == start_at);
                abort1 = (i == abort_at);
            end
        end
        start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy0); end
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done0); end
        if (pass0 !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass0); end
        if (err0 !== 3'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err0); end
        if (gate_in0 !== 2'd0) begin n_fail++; $display("FAIL reset_gate_in got %b want 00", gate_in0); end
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        if (err1 !== 3'd0) begin n_fail++; $display("FAIL reset_err1 got %0d want 0", err1); end
        rst_n = 1'b1;
    endtask

    task automatic test_or_sweep;
        int bc, dc, da; logic pd;
        mode0 = 0;
        kick(0);
        observe(0, -1, -1, bc, dc, da, pd);
        n_checks += 7;
        if (bc !== 17) begin n_fail++; $display("FAIL or_busy_len got %0d want 17", bc); end
        if (dc !== 1) begin n_fail++; $display("FAIL or_done_count got %0d want 1", dc); end
        if (da !== 16) begin n_fail++; $display("FAIL or_done_at got %0d want 16", da); end
        if (pd !== 1'b1) begin n_fail++; $display("FAIL or_pass_at_done got %b want 1", pd); end
        if (err0 !== 3'd0) begin n_fail++; $display("FAIL or_err got %0d want 0", err0); end
        if (pass0 !== 1'b1) begin n_fail++; $display("FAIL or_pass_hold got %b want 1", pass0); end
        if (gate_in0 !== 2'b11) begin n_fail++; $display("FAIL or_gate_in_hold got %b want 11", gate_in0); end
    endtask

    task automatic test_stuck(input int mode, input logic [2:0] exp_err, input logic [1:0] exp_vec, input logic exp_z);
        int bc, dc, da; logic pd;
        mode0 = mode;
        kick(0);
        observe(0, -1, -1, bc, dc, da, pd);
        n_checks += 3;
        if (err0 !== exp_err) begin n_fail++; $display("FAIL stuck%0d_err got %0d want %0d", mode - 1, err0, exp_err); end
        if (pd !== 1'b0 || pass0 !== 1'b0) begin n_fail++; $display("FAIL stuck%0d_pass got %b/%b want 0/0", mode - 1, pd, pass0); end
        if (dc !== 1) begin n_fail++; $display("FAIL stuck%0d_done got %0d want 1", mode - 1, dc); end
`ifdef GATE_SWEEP_CAPTURE_EN
        n_checks += 2;
        if (ffv0 !== exp_vec) begin n_fail++; $display("FAIL stuck%0d_ffvec got %b want %b", mode - 1, ffv0, exp_vec); end
        if (ffz0 !== exp_z) begin n_fail++; $display("FAIL stuck%0d_ffz got %b want %b", mode - 1, ffz0, exp_z); end
`endif
    endtask

    task automatic test_back_to_back;
        int bc, dc, da; logic pd;
        mode0 = 0;
        kick(0);
        observe(0, 10, -1, bc, dc, da, pd);
        n_checks += 3;
        if (dc !== 1) begin n_fail++; $display("FAIL restart_done_count got %0d want 1", dc); end
        if (bc !== 17) begin n_fail++; $display("FAIL restart_busy_len got %0d want 17", bc); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL restart_no_resweep got busy %b want 0", busy0); end
    endtask

    task automatic test_abort;
        int bc, dc, da; logic pd;
        mode0 = 1;
        kick(0);
        observe(0, -1, 11, bc, dc, da, pd);
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (bc !== 12) begin n_fail++; $display("FAIL abort_busy_len got %0d want 12", bc); end
        if (dc !== 0 || done0 !== 1'b0) begin n_fail++; $display("FAIL abort_done got %0d want 0", dc); end
        if (err0 !== 3'd1) begin n_fail++; $display("FAIL abort_err got %0d want 1", err0); end
        if (pass0 !== 1'b0) begin n_fail++; $display("FAIL abort_pass got %b want 0", pass0); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy0); end
`ifdef GATE_SWEEP_CAPTURE_EN
        n_checks += 1;
        if (ffv0 !== 2'b01 || ffz0 !== 1'b0) begin n_fail++; $display("FAIL abort_capture got %b/%b want 01/0", ffv0, ffz0); end
`endif
    endtask

    task automatic test_abort_idle_done;
        int bc, dc, da; logic pd;
        mode0 = 0;
        @(posedge clk); #1;
        start0 = 1'b1; abort0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(negedge clk);
        n_checks += 1;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL start_abort_idle got busy %b want 1", busy0); end
        abort0 = 1'b0;
        observe(0, -1, 15, bc, dc, da, pd);
        n_checks += 3;
        if (dc !== 1) begin n_fail++; $display("FAIL abort_in_done got done count %0d want 1", dc); end
        if (bc !== 16) begin n_fail++; $display("FAIL abort_in_done_len got %0d want 16", bc); end
        if (pass0 !== 1'b1) begin n_fail++; $display("FAIL abort_in_done_pass got %b want 1", pass0); end
    endtask

    task automatic test_reset_midsweep;
        int bc, dc, da; logic pd;
        mode0 = 0;
        kick(0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks += 5;
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy0); end
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %b want 0", done0); end
        if (pass0 !== 1'b0) begin n_fail++; $display("FAIL midreset_pass got %b want 0", pass0); end
        if (err0 !== 3'd0) begin n_fail++; $display("FAIL midreset_err got %0d want 0", err0); end
        if (gate_in0 !== 2'd0) begin n_fail++; $display("FAIL midreset_gate_in got %b want 00", gate_in0); end
        rst_n = 1'b1;
        lut1 = 4'b0110;
        kick(1);
        observe(1, -1, -1, bc, dc, da, pd);
        n_checks += 4;
        if (bc !== 9) begin n_fail++; $display("FAIL settle0_busy_len got %0d want 9", bc); end
        if (da !== 8 || dc !== 1) begin n_fail++; $display("FAIL settle0_done got at %0d x%0d want at 8 x1", da, dc); end
        if (err1 !== 3'd0) begin n_fail++; $display("FAIL settle0_err got %0d want 0", err1); end
        if (pd !== 1'b1) begin n_fail++; $display("FAIL settle0_pass got %b want 1", pd); end
    endtask

    task automatic test_random;
        int bc, dc, da; logic pd;
        int exp_err; int ff_v; logic ff_z;
        for (int it = 0; it < 10; it++) begin
            for (int sel = 0; sel < 2; sel++) begin
                logic [3:0] lut;
                lut = (it == 0) ? ((sel == 0) ? 4'b1110 : 4'b0110) : 4'($urandom_range(0, 15));
                exp_err = 0; ff_v = 0; ff_z = 1'b0;
                for (int v = 0; v < 4; v++)
                    if (lut[v] != ref_fn(sel ? 2 : 0, v)) begin
                        if (exp_err == 0) begin ff_v = v; ff_z = lut[v]; end
                        exp_err++;
                    end
                if (sel == 0) begin mode0 = 3; lut0 = lut; end else lut1 = lut;
                kick(sel);
                observe(sel, -1, -1, bc, dc, da, pd);
                n_checks += 3;
                if ((sel ? err1 : err0) !== 3'(exp_err)) begin n_fail++; $display("FAIL rand_err dut%0d lut %b got %0d want %0d", sel, lut, sel ? err1 : err0, exp_err); end
                if (pd !== (exp_err == 0)) begin n_fail++; $display("FAIL rand_pass dut%0d lut %b got %b want %b", sel, lut, pd, exp_err == 0); end
                if (da !== (sel ? 8 : 16)) begin n_fail++; $display("FAIL rand_len dut%0d got %0d want %0d", sel, da, sel ? 8 : 16); end
`ifdef GATE_SWEEP_CAPTURE_EN
                n_checks += 1;
                if ((sel ? {ffv1, ffz1} : {ffv0, ffz0}) !== {2'(ff_v), ff_z}) begin
                    n_fail++;
                    $display("FAIL rand_capture dut%0d got %b want %b", sel, sel ? {ffv1, ffz1} : {ffv0, ffz0}, {2'(ff_v), ff_z});
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_or_sweep();
        test_stuck(1, 3'd3, 2'b01, 1'b0);
        test_stuck(2, 3'd1, 2'b00, 1'b1);
        test_back_to_back();
        test_abort();
        test_abort_idle_done();
        test_reset_midsweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Self-checking sequencer for a small combinational gate under test (OR gate by default).
- On start, steps through every input combination, waits a settle interval, samples the gate output, compares it against a built-in reference function, and reports the mismatch count.
- Sits between a top-level test/control harness and the gate instance. Replaces hand-written stimulus sequences with a reusable synthesizable sweep.

Parameters:
- N_IN, 2, number of gate inputs driven; the sweep covers 2**N_IN vectors.
- SETTLE, 2, wait cycles between applying a vector and sampling; legal range 0..15.
- OP, 0, reference function: 0=OR, 1=AND, 2=XOR, 3=NOR, 4=NAND, 5=XNOR; other values are illegal and the reference output is 0.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  synchronous abort of a running sweep.
- gate_in  out  N_IN  registered vector driven to the gate; bit 0 = x, bit 1 = y.
- gate_z  in  1  gate output being checked.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when a sweep completes; never asserted on abort.
- pass  out  1  high in the done cycle and afterwards while err_count==0; cleared on start.
- err_count  out  N_IN+1  mismatches in the last sweep; saturates at 2**N_IN.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, gate_in=0, busy=0, done=0, pass=0, err_count=0, internal vec=0, settle counter=0. Reset mid-sweep aborts it with these values. No done pulse.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE: start=1 -> DRIVE; vec=0, err_count=0, pass=0, busy=1 next cycle.
- DRIVE (1 cycle): gate_in<=vec, settle counter loaded with SETTLE. Goes to WAIT, or directly to SAMPLE if SETTLE==0.
- WAIT: counter decrements each cycle; when it reaches 1 -> SAMPLE. WAIT occupies exactly SETTLE cycles.
- SAMPLE (1 cycle): compare gate_z with ref(vec); on mismatch err_count+=1, saturating. If vec==2**N_IN-1 -> DONE, else vec+=1 -> DRIVE.
- Per-vector cost is SETTLE+2 cycles. Sweep length is 2**N_IN*(SETTLE+2) cycles from the first DRIVE cycle to the last SAMPLE cycle. Default: 16 cycles.
- DONE (1 cycle): done=1, pass=(err_count==0), busy=1. Next state IDLE, busy=0.
- gate_in holds its last value in IDLE and DONE. It returns to 0 only on reset or at the next DRIVE.
- vec wrap: the final increment never occurs; vec is not advanced past 2**N_IN-1.
- abort=1 in DRIVE/WAIT/SAMPLE -> IDLE next cycle. busy=0, done stays 0, err_count holds its partial value, pass=0.
- abort takes priority over the SAMPLE comparison in the same cycle; that sample is not counted.
- abort in IDLE or DONE is ignored. DONE still pulses.
- start while busy is ignored. start and abort together in IDLE: start wins (abort is ignored in IDLE).
- gate_z is sampled only in SAMPLE; its value in other states is don't-care.

Optional Feature:
- Macro GATE_SWEEP_CAPTURE_EN.
- Defined: adds outputs first_fail_vec (N_IN) and first_fail_z (1). Reset/start clear both to 0 and clear an internal captured flag. The first mismatching SAMPLE of a sweep latches vec and gate_z; later mismatches do not overwrite them. Values hold after DONE/abort.
- Undefined: these ports and registers do not exist. Core behaviour is identical.

Decomposition:
- Package gate_sweep_pkg: state enum type, OP code localparams (OP_OR..OP_XNOR), SETTLE_W=4.
- Sub-module gate_ref_model: purely combinational, parameters N_IN and OP, input vec, output expected. Reduction OR/AND/XOR plus optional inversion.
- The controller contains the FSM, counters and compare logic.

Test Plan:
- OP=0, gate_z driven by a real OR of gate_in, start at cycle 5 -> busy high cycles 6..22, done pulse at cycle 22, err_count=0, pass=1, final gate_in=2'b11.
- OP=0, gate_z stuck-at-0 -> err_count=3, pass=0. With CAPTURE_EN: first_fail_vec=2'b01, first_fail_z=0.
- OP=0, gate_z stuck-at-1 -> err_count=1, pass=0. With CAPTURE_EN: first_fail_vec=2'b00, first_fail_z=1.
- start pulsed again at cycle 10 of a sweep -> ignored; a single done pulse; sweep length unchanged.
- abort in the SAMPLE state of vector 2 with a stuck-at-0 gate -> next cycle IDLE, busy=0, no done, err_count=1 (vector 1 only).
- rst_n=0 during WAIT of vector 1, then start with SETTLE=0 -> all outputs at reset values; new sweep takes 8 cycles, done pulses, err_count=0.
